// File: rtl/jtag_master.sv
// JTAG master: runs TAP reset, DR scan and IR scan sequences on a divided TCK
// and returns the captured TDO bits right-aligned.
module jtag_master #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_reset,
  input  logic        cmd_ir,
  input  logic [4:0]  cmd_len,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        tck_o,
  output logic        tms_o,
  output logic        tdi_o,
  input  logic        tdo_i
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  // state is the TAP state the target sits in during the TCK in progress
  typedef enum logic [2:0] {
    TLR_SEQ, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE
  } state_t;

  state_t      state, nxt_state;
  logic [7:0]  div_cnt;
  logic [2:0]  tlr_cnt;
  logic [4:0]  bit_cnt, len, nb;
  logic        is_ir;
  logic [31:0] data, cap;
  logic        nxt_tms, nxt_tdi, finish, phase_end;

  assign phase_end = (div_cnt == DIV_LAST);

  // Next TAP state and the TMS/TDI to present for the following TCK
  always_comb begin
    nxt_state = state;
    nxt_tms   = 1'b0;
    nxt_tdi   = 1'b0;
    finish    = 1'b0;
    nb        = 5'd0;
    if (state == SHIFT) nb = bit_cnt + 5'd1;
    case (state)
      TLR_SEQ: begin
        finish    = (tlr_cnt == 3'd5);
        nxt_state = finish ? IDLE : TLR_SEQ;
      end
      IDLE:    nxt_state = SEL_DR;
      SEL_DR:  nxt_state = is_ir ? SEL_IR : CAPTURE;
      SEL_IR:  nxt_state = CAPTURE;
      CAPTURE: nxt_state = SHIFT;
      SHIFT:   nxt_state = tms_o ? EXIT1 : SHIFT;
      EXIT1:   nxt_state = UPDATE;
      UPDATE: begin
        nxt_state = IDLE;
        finish    = 1'b1;
      end
      default: nxt_state = TLR_SEQ;
    endcase
    case (nxt_state)
      TLR_SEQ: nxt_tms = (tlr_cnt != 3'd4);
      SEL_DR:  nxt_tms = is_ir;
      SHIFT: begin
        nxt_tms = (nb == len);
        nxt_tdi = data[nb];
      end
      EXIT1:   nxt_tms = 1'b1;
      default: nxt_tms = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= TLR_SEQ;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      tck_o     <= 1'b0;
      tms_o     <= 1'b1;
      tdi_o     <= 1'b0;
      div_cnt   <= '0;
      tlr_cnt   <= '0;
      bit_cnt   <= '0;
      len       <= '0;
      is_ir     <= 1'b0;
      data      <= '0;
      cap       <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (cmd_ready) begin
        if (cmd_valid) begin
          cmd_ready <= 1'b0;
          div_cnt   <= '0;
          tck_o     <= 1'b0;
          tms_o     <= 1'b1;
          tdi_o     <= 1'b0;
          tlr_cnt   <= '0;
          bit_cnt   <= '0;
          if (cmd_reset) begin
            state <= TLR_SEQ;
          end else begin
            state <= IDLE;
            is_ir <= cmd_ir;
            len   <= cmd_len;
            data  <= cmd_data;
            cap   <= '0;
          end
        end
      end else if (!phase_end) begin
        div_cnt <= div_cnt + 8'd1;
      end else begin
        div_cnt <= '0;
        if (!tck_o) begin
          tck_o <= 1'b1;
          if (state == SHIFT) cap[bit_cnt] <= tdo_i;
        end else begin
          // end of high phase: new TCK period starts, drive its TMS/TDI
          tck_o   <= 1'b0;
          state   <= nxt_state;
          tms_o   <= nxt_tms;
          tdi_o   <= nxt_tdi;
          bit_cnt <= nb;
          if (state == TLR_SEQ) tlr_cnt <= tlr_cnt + 3'd1;
          if (finish) begin
            cmd_ready <= 1'b1;
            if (state == UPDATE) begin
              rsp_valid <= 1'b1;
              rsp_data  <= cap;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_master.sv
// Bench for jtag_master: IEEE 1149.1 TAP model on the pins, scoreboard for
// scan responses, directed command vectors with hand-computed expectations.
`timescale 1ns/1ps
module tb_jtag_master;

  localparam int CLK_DIV = 2;

  logic        clk = 1'b0;
  logic        reset_n, cmd_valid, cmd_ready, cmd_reset, cmd_ir;
  logic [4:0]  cmd_len;
  logic [31:0] cmd_data, rsp_data;
  logic        rsp_valid, tck_o, tms_o, tdi_o, tdo_i;

  int checks = 0;
  int errors = 0;

  jtag_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_reset(cmd_reset), .cmd_ir(cmd_ir), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .tck_o(tck_o), .tms_o(tms_o),
    .tdi_o(tdi_o), .tdo_i(tdo_i)
  );

  always #5 clk = ~clk;

  // ---------------- TAP model ----------------
  typedef enum logic [3:0] {
    TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PSDR, EX2DR, UPDR,
    SELIR, CAPIR, SHIR, EX1IR, PSIR, EX2IR, UPIR
  } tap_t;

  tap_t tap = TLR;
  logic tms_q[$];
  int   bad_tdi = 0;
  logic tdo_tie = 1'b0;
  logic force_shift = 1'b0;

  function automatic tap_t tap_next(tap_t s, logic m);
    case (s)
      TLR:   return m ? TLR   : RTI;
      RTI:   return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR: return m ? EX1DR : SHDR;
      SHDR:  return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDR  : PSDR;
      PSDR:  return m ? EX2DR : PSDR;
      EX2DR: return m ? UPDR  : SHDR;
      UPDR:  return m ? SELDR : RTI;
      SELIR: return m ? TLR   : CAPIR;
      CAPIR: return m ? EX1IR : SHIR;
      SHIR:  return m ? EX1IR : SHIR;
      EX1IR: return m ? UPIR  : PSIR;
      PSIR:  return m ? EX2IR : PSIR;
      EX2IR: return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge tck_o or posedge force_shift) begin
    if (force_shift) tap <= SHDR;
    else begin
      tms_q.push_back(tms_o);
      if (!(tap == SHDR || tap == SHIR) && tdi_o) bad_tdi++;
      tap <= tap_next(tap, tms_o);
    end
  end

  assign tdo_i = tdo_tie ? 1'b1 : ((tap == SHDR || tap == SHIR) ? tdi_o : 1'b0);

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [31:0] sb[$];

  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) chk("unexpected_rsp_valid", 64'(rsp_data), 64'hDEAD_0000_0000_0000);
      else chk("rsp_data", 64'(rsp_data), 64'(sb.pop_front()));
    end
  end

  // every TCK high phase lasts CLK_DIV clk cycles (reset aborts excluded)
  int hi_run = 0;
  always @(negedge clk) begin
    if (tck_o) hi_run++;
    else begin
      if (hi_run != 0 && reset_n) chk("tck_high_len", 64'(hi_run), 64'(CLK_DIV));
      hi_run = 0;
    end
  end

  function automatic logic [63:0] tms_since(int start);
    logic [63:0] v = '0;
    for (int i = start; i < tms_q.size(); i++) v[i - start] = tms_q[i];
    return v;
  endfunction

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
    end while (!cmd_ready && n < 2000);
  endtask

  task automatic issue(input logic r, input logic ir, input logic [4:0] l, input logic [31:0] d);
    @(negedge clk);
    cmd_reset = r; cmd_ir = ir; cmd_len = l; cmd_data = d; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_reset = 1'b1; cmd_ir = 1'b1; cmd_len = 5'd3; cmd_data = 32'h0BAD_F00D;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n, start;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_reset = 1'b0; cmd_ir = 1'b0;
    cmd_len = '0; cmd_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_tck", 64'(tck_o), 64'd0);
    chk("rst_tms", 64'(tms_o), 64'd1);
    chk("rst_tdi", 64'(tdi_o), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);

    // automatic TAP reset after release
    start = tms_q.size();
    reset_n = 1'b1;
    wait_ready(n);
    chk("tlr_latency", 64'(n), 64'd24);
    chk("tlr_tcks", 64'(tms_q.size() - start), 64'd6);
    chk("tlr_tms", tms_since(start), 64'h1F);
    chk("tlr_tap_rti", 64'(tap), 64'(RTI));

    // DR scan, 8 bits loopback
    sb.push_back(32'h0000_00A5);
    start = tms_q.size();
    issue(1'b0, 1'b0, 5'd7, 32'h0000_00A5);
    wait_ready(n);
    chk("dr8_latency", 64'(n), 64'd52);
    chk("dr8_tcks", 64'(tms_q.size() - start), 64'd13);
    chk("dr8_tms", tms_since(start), 64'hC01);
    chk("dr8_tap_rti", 64'(tap), 64'(RTI));

    // IR scan, 5 bits, TDO tied high
    tdo_tie = 1'b1;
    sb.push_back(32'h0000_001F);
    start = tms_q.size();
    issue(1'b0, 1'b1, 5'd4, 32'h0000_0011);
    wait_ready(n);
    tdo_tie = 1'b0;
    chk("ir5_latency", 64'(n), 64'd44);
    chk("ir5_tcks", 64'(tms_q.size() - start), 64'd11);
    chk("ir5_tms", tms_since(start), 64'h303);
    chk("ir5_tap_rti", 64'(tap), 64'(RTI));

    // back-to-back: 32-bit DR then 1-bit DR with cmd_valid held
    sb.push_back(32'hDEAD_BEEF);
    sb.push_back(32'h0000_0001);
    start = tms_q.size();
    @(negedge clk);
    cmd_reset = 1'b0; cmd_ir = 1'b0; cmd_len = 5'd31; cmd_data = 32'hDEAD_BEEF; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_len = 5'd0; cmd_data = 32'h0000_0001;
    wait_ready(n);
    chk("dr32_latency", 64'(n), 64'd148);
    chk("dr32_tcks", 64'(tms_q.size() - start), 64'd37);
    chk("dr32_tms", tms_since(start), 64'h0000_000C_0000_0001);
    chk("b2b_gap_tck_low", 64'(tck_o), 64'd0);
    start = tms_q.size();
    @(posedge clk);
    @(negedge clk);
    chk("b2b_ready_one_cycle", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b0;
    wait_ready(n);
    chk("dr1_latency", 64'(n), 64'd24);
    chk("dr1_tcks", 64'(tms_q.size() - start), 64'd6);
    chk("dr1_tms", tms_since(start), 64'h19);

    // TAP reset command while the target sits in Shift-DR
    @(negedge clk); force_shift = 1'b1;
    @(negedge clk); force_shift = 1'b0;
    start = tms_q.size();
    issue(1'b1, 1'b0, 5'd9, 32'hFFFF_FFFF);
    wait_ready(n);
    chk("cmdrst_latency", 64'(n), 64'd24);
    chk("cmdrst_tms", tms_since(start), 64'h1F);
    chk("cmdrst_tap_rti", 64'(tap), 64'(RTI));
    chk("cmdrst_rsp_hold", 64'(rsp_data), 64'h1);

    // reset asserted during shift TCK 3 of a DR scan
    start = tms_q.size();
    issue(1'b0, 1'b0, 5'd7, 32'h0000_00FF);
    for (int i = 0; i < 200; i++) begin
      if (tms_q.size() - start >= 7) break;
      @(negedge clk);
    end
    chk("abort_reached_shift3", 64'(tms_q.size() - start), 64'd7);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_tck", 64'(tck_o), 64'd0);
    chk("abort_tms", 64'(tms_o), 64'd1);
    chk("abort_ready", 64'(cmd_ready), 64'd0);
    chk("abort_rsp_data", 64'(rsp_data), 64'd0);
    @(negedge clk);
    start = tms_q.size();
    reset_n = 1'b1;
    wait_ready(n);
    chk("abort_tlr_latency", 64'(n), 64'd24);
    chk("abort_tlr_tms", tms_since(start), 64'h1F);
    chk("abort_tap_rti", 64'(tap), 64'(RTI));

    repeat (5) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("tdi_zero_off_shift", 64'(bad_tdi), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_master.md
JTAG_MASTER -- requirements
Module: jtag_master

Interface
REQ-001 Parameter CLK_DIV, 2: number of clk cycles per TCK half-period; legal range 1..255.
REQ-002 Port clk  input  1  single system clock; all logic sampled on its rising edge.
REQ-003 Port reset_n  input  1  reset, synchronous, active-low.
REQ-004 Port cmd_valid  input  1  command request.
REQ-005 Port cmd_ready  output  1  block idle in Run-Test/Idle (RTI) and able to accept a command.
REQ-006 Port cmd_reset  input  1  when 1, the command is a TAP reset; cmd_ir, cmd_len and cmd_data are ignored.
REQ-007 Port cmd_ir  input  1  1 = IR scan, 0 = DR scan.
REQ-008 Port cmd_len  input  5  scan length minus one (1..32 bits).
REQ-009 Port cmd_data  input  32  TDI data, shifted LSB first.
REQ-010 Port rsp_valid  output  1  one-cycle pulse when scan data is available.
REQ-011 Port rsp_data  output  32  captured TDO bits, right-aligned.
REQ-012 Port tck_o  output  1  JTAG TCK to the target TAP.
REQ-013 Port tms_o  output  1  JTAG TMS.
REQ-014 Port tdi_o  output  1  JTAG TDI.
REQ-015 Port tdo_i  input  1  JTAG TDO from the target.

Function
REQ-016 Command accepted on a clk edge with cmd_valid=1 and cmd_ready=1; command fields latched on that edge; cmd_ready=0 from the next cycle until the sequence completes.
REQ-017 TCK generation while busy: each TCK period is a low phase of CLK_DIV clk cycles followed by a high phase of CLK_DIV clk cycles; tck_o=0 whenever idle.
REQ-018 Signal timing: tms_o and tdi_o update only at the start of a low phase; tdo_i is registered on the clk edge where tck_o goes 0->1.
REQ-019 FSM states: TLR_SEQ, IDLE(RTI), SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE; TAP state tracking follows IEEE 1149.1 transitions.
REQ-020 TAP reset sequence: 6 TCKs with TMS = 1,1,1,1,1,0 ending in RTI; produces no rsp_valid.
REQ-021 DR scan: TMS = 1,0,0 (to Shift-DR), then N shift TCKs, then 1,0 (Update -> RTI); total N+5 TCKs.
REQ-022 IR scan: TMS = 1,1,0,0 (to Shift-IR), then N shift TCKs, then 1,0; total N+6 TCKs.
REQ-023 Shift TCKs: N = cmd_len+1; tms_o=0 for the first N-1 and 1 on the Nth; tdi_o = cmd_data[i] on shift TCK i (i = 0..N-1); tdi_o=0 on all non-shift TCKs.
REQ-024 rsp_data[i] = tdo_i sampled at the rising edge of shift TCK i; rsp_data[31:N] = 0; TDO ignored on non-shift TCKs.
REQ-025 Completion: in the clk cycle after the final high phase, tck_o=0, cmd_ready=1, and for scans rsp_valid=1 for exactly one cycle; rsp_data holds until the next scan completes.
REQ-026 Latency: acceptance edge to cmd_ready=1 is TCKs*2*CLK_DIV clk cycles.
REQ-027 Back-to-back: with cmd_valid held high, the next command is accepted on the first cycle cmd_ready=1; tck_o stays 0 for at least that one cycle.
REQ-028 Command inputs are ignored while cmd_ready=0.
REQ-029 N=1: a single shift TCK carries tms_o=1.
REQ-030 N=32: all rsp_data bits are valid; no wrap or truncation.

Reset
REQ-031 When reset_n=0 at a clk edge: tck_o=0, tms_o=1, tdi_o=0, cmd_ready=0, rsp_valid=0, rsp_data=0; FSM, counters and shift registers are cleared.
REQ-032 After reset_n returns to 1, the block automatically runs the TAP reset sequence (REQ-020) before asserting cmd_ready.
REQ-033 Reset asserted mid-scan aborts the scan on that edge; the aborted scan produces no rsp_valid.

Verification
REQ-034 Reset release, CLK_DIV=2 -> 6 TCKs with TMS 1,1,1,1,1,0, each 4 clk long; cmd_ready=1 exactly 24 clk after release; rsp_valid stays 0.
REQ-035 DR scan, cmd_len=7, cmd_data=0xA5, tdo_i looped from tdi_o through a TAP model in Shift -> TMS 1,0,0,0×7,1,1,0; rsp_data=0x000000A5; 13 TCKs = 52 clk.
REQ-036 IR scan, cmd_len=4, cmd_data=0x11, tdo_i tied 1 -> TMS 1,1,0,0,0,0,0,0,1,1,0; rsp_data=0x0000001F.
REQ-037 DR scan, cmd_len=31, cmd_data=0xDEADBEEF, loopback -> rsp_data=0xDEADBEEF; cmd_valid held high for two commands -> cmd_ready high exactly one cycle between them.
REQ-038 reset_n low during shift TCK 3 of a DR scan -> next cycle tck_o=0, tms_o=1; no rsp_valid; fresh TLR sequence after release.
REQ-039 cmd_reset=1 accepted while the TAP model is in Shift-DR -> model ends in RTI; no rsp_valid; rsp_data unchanged.
